// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
//   skid_state_t : occupancy state of the stage; the encoding doubles as the
//                  entry count (EMPTY=0, ONE=1, FULL=2).
//   PIPE_CTRL_W  : default control-strobe width.
//   PIPE_DATA_W  : default payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int PIPE_CTRL_W = 4;
    localparam int PIPE_DATA_W = 36;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: a valid bit plus ctrl and data.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear_i    : synchronous clear of valid/ctrl (wins over load_i)
//   load_i     : load ctrl_i/data_i and mark the slot valid
//   ctrl_i     : control strobes to store
//   data_i     : payload to store
//   valid_o    : slot holds an entry
//   ctrl_o     : stored control strobes
//   data_o     : stored payload (kept across clear so the stage output can hold it)
module pipe_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Data is intentionally left untouched by clear so a bubble still shows
    // the last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, registered
// in_ready, synchronous flush and a saturating stall counter.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous squash, empties the stage
//   in_valid/in_ready   : upstream handshake (in_ready is registered)
//   in_ctrl/in_data     : upstream entry
//   out_valid/out_ready : downstream handshake
//   out_ctrl            : control strobes, forced to zero on a bubble
//   out_data            : payload, holds its last value when invalid
//   occupancy           : entries held (0..2)
//   stall_cnt           : saturating count of out_valid & ~out_ready cycles
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              accept, xfer;
    logic              main_load, main_clear, main_sel_skid;
    logic              skid_load, skid_clear;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, skid_data, main_data_in;

    assign accept = in_valid & in_ready_q;
    assign xfer   = main_valid & out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (main_clear),
        .load_i  (main_load),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    // Main refills from skid when draining FULL, otherwise from upstream.
    assign main_ctrl_in = main_sel_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_sel_skid ? skid_data : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    // Flush overrides every transition and discards the skid entry rather
    // than promoting it. FULL never sees an accept because in_ready is low.
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        main_load = 1'b1;
                    end else if (xfer) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        state_d       = ONE;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // in_ready for next cycle is the complement of the skid slot's next valid.
    assign in_ready_d = ~(skid_load | (skid_valid & ~skid_clear));

    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage. A reference FIFO model (capacity 2)
// in the monitor predicts acceptance, ordering, occupancy and stall counts.
module tb_pipe_skid_stage;

    localparam int CW = 4;
    localparam int DW = 36;
    localparam int NW = 3;
    localparam int STALL_MAX = (1 << NW) - 1;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    entry_t        expQ[$];
    int            stallModel = 0;
    logic [DW-1:0] lastData = '0;

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        checkOutput("rst_out_data",  64'(out_data),  64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard: on each falling edge compare the DUT against the
    // model, then advance the model by the handshake about to be clocked.
    initial begin : monitor
        entry_t e;
        bit acc, xf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expQ.delete();
                stallModel = 0;
                lastData   = '0;
            end else begin
                checkOutput("occupancy", 64'(occupancy), 64'(expQ.size()));
                checkOutput("in_ready",  64'(in_ready),  64'(expQ.size() < 2));
                checkOutput("out_valid", 64'(out_valid), 64'(expQ.size() > 0));
                checkOutput("stall_cnt", 64'(stall_cnt), 64'(stallModel));
                if (expQ.size() > 0) begin
                    checkOutput("out_ctrl", 64'(out_ctrl), 64'(expQ[0].ctrl));
                    checkOutput("out_data", 64'(out_data), 64'(expQ[0].data));
                    lastData = expQ[0].data;
                end else begin
                    checkOutput("bubble_ctrl", 64'(out_ctrl), 64'd0);
                    checkOutput("bubble_data", 64'(out_data), 64'(lastData));
                end
                xf  = (expQ.size() > 0) && out_ready;
                acc = in_valid && (expQ.size() < 2);
                if ((expQ.size() > 0) && !out_ready && (stallModel < STALL_MAX))
                    stallModel++;
                if (xf)
                    e = expQ.pop_front();
                if (flush) begin
                    expQ.delete();
                end else if (acc) begin
                    e.ctrl = in_ctrl;
                    e.data = in_data;
                    expQ.push_back(e);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass-through stream with downstream always ready, then a bubble.
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'hF, 36'hDEAD, 1'b1, 1'b0);

        // Backpressure: C is offered while FULL and must be held off.
        applyStimulus(1'b1, 4'h1, 36'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 36'hB, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 36'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 36'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 36'hC, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h3, 36'hC, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'h0, 36'h0, 1'b1, 1'b0);

        // Reset mid-traffic with the stage full.
        applyStimulus(1'b1, 4'h5, 36'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 36'h66, 1'b0, 1'b0);
        doReset();

        // Flush while FULL with a same-cycle input that must be dropped.
        applyStimulus(1'b1, 4'b1001, 36'h123, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1001, 36'h456, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 36'h789, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'h0, 36'h0, 1'b1, 1'b0);

        // Flush coinciding with an output transfer.
        applyStimulus(1'b1, 4'h7, 36'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h8, 36'h88, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'h0, 36'h0, 1'b1, 1'b0);

        // Stall-counter saturation.
        doReset();
        applyStimulus(1'b1, 4'h2, 36'hBEEF, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 4'h0, 36'h0, 1'b0, 1'b0);
        checkOutput("stall_saturated", 64'(stall_cnt), 64'(STALL_MAX));
        repeat (2) applyStimulus(1'b0, 4'h0, 36'h0, 1'b1, 1'b0);

        // Randomized traffic.
        doReset();
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), CW'($urandom), {4'($urandom), 32'($urandom)},
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end
        repeat (4) applyStimulus(1'b0, 4'h0, 36'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline-stage register replacing the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control field (write/read/select strobes) and a data payload between stages using a valid/ready handshake, with a 2-entry skid buffer so `in_ready` is registered. It also supports synchronous flush for branch/hazard squash and a saturating stall counter for performance debug. Control bits are forced to zero whenever the stage holds a bubble, so downstream stages never see stray MemWrite/RegWrite strobes.

## Interface
- `CTRL_W`, 4: control-strobe field width; bits are zeroed on bubble/flush.
- `DATA_W`, 36: payload width (e.g. ALU value 16 + store data 16 + dst reg 4).
- `CNT_W`, 16: stall-counter width; the counter saturates.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `flush`  in  1: synchronous squash; empties the stage.
- `in_valid`  in  1: upstream holds a valid entry.
- `in_ready`  out  1: stage can accept; registered.
- `in_ctrl`  in  CTRL_W: upstream control strobes.
- `in_data`  in  DATA_W: upstream payload.
- `out_valid`  out  1: stage presents a valid entry.
- `out_ready`  in  1: downstream accepts.
- `out_ctrl`  out  CTRL_W: control strobes, gated by `out_valid`.
- `out_data`  out  DATA_W: payload; holds its last value when invalid.
- `occupancy`  out  2: entries held (0, 1 or 2).
- `stall_cnt`  out  CNT_W: cycles with `out_valid & ~out_ready`; saturates at all-ones.

## Operation
- **Storage:** main slot (drives outputs) and skid slot, each holding ctrl, data and a valid bit.
- **Transfer rules:**
  - Input accept occurs when `in_valid & in_ready`.
  - Output transfer occurs when `out_valid & out_ready`.
- **States and transitions:** EMPTY(0), ONE(1), FULL(2).
  - EMPTY:
    - accept → ONE, and the main slot loads the input.
    - otherwise stay.
  - ONE:
    - accept with transfer → ONE, and main is replaced by the input.
    - transfer only → EMPTY.
    - accept only → FULL, and the input goes to skid.
    - neither → stay.
  - FULL:
    - `in_ready` = 0.
    - transfer → ONE, and skid moves to main.
    - otherwise hold.
- **Flush:** highest priority. It takes the stage to EMPTY next cycle, clears both valid bits and drops any same-cycle input. The skid content is discarded and not promoted.
- **Ordering:** strict FIFO; an entry is never duplicated or dropped except by flush.
- **Output gating:**
  - `out_ctrl` = main ctrl when valid, else 0.
  - `out_data` is not gated.
  - `out_valid` = main valid.
  - `in_ready` = ~skid valid, registered.
- **Stall counter:** increments on each cycle with `out_valid & ~out_ready`, including during flush-cycle evaluation. It stops at 2^CNT_W−1 and clears only on reset.

## Timing
- Reset (async, immediate):
  - `out_valid` = 0, `in_ready` = 1, `out_ctrl` = 0, `out_data` = 0.
  - `occupancy` = 0, `stall_cnt` = 0, state = EMPTY.
- Latency: input accepted at edge N appears at the outputs after edge N (visible cycle N+1); throughput is 1 entry per cycle.
- `in_ready` deasserts the cycle after the stage reaches FULL and reasserts the cycle after the first transfer out of FULL.
- `flush` with `out_ready` = 1 in the same cycle: the output transfer still counts downstream, and the stage is EMPTY afterwards.
- Reset asserted mid-transfer: all contents are lost, with no partial state.
- `in_ctrl`/`in_data` are sampled only on accept. Inputs with `in_valid` = 0 are don't-care.

## Structure
- Package `pipe_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t`.
  - Default width constants `PIPE_CTRL_W` = 4 and `PIPE_DATA_W` = 36.
- Sub-module `pipe_slot`:
  - Holds the valid + ctrl + data register with load-enable and synchronous clear.
  - Instantiated twice (main, skid).
- The FSM, the ctrl gating and the saturating counter live in the top module.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle → outputs go to 0 immediately, `in_ready` = 1, `occupancy` = 0.
- **Pass-through:** stream in_data 0x1..0x8 with `out_ready` = 1 held → out_data 0x1..0x8 appear one cycle later, back-to-back, `occupancy` = 1 throughout.
- **Backpressure:**
  - Send 0xA, 0xB and 0xC with `out_ready` = 0 → `occupancy` 1→2, `in_ready` drops after 0xB and 0xC is held off.
  - Raise `out_ready` → outputs 0xA, 0xB, 0xC in order, and `stall_cnt` equals the stalled cycles.
- **Flush while FULL:** stage holds ctrl = 4'b1001; assert `flush` with `in_valid` = 1 → next cycle `out_valid` = 0, `out_ctrl` = 0, `occupancy` = 0, and the new input is absent from the output.
- **Bubble gating:** after a transfer with no new input → `out_ctrl` = 0 while `out_data` keeps its last value.
- **Saturation:** with CNT_W = 3, stall for 10 cycles → `stall_cnt` = 7 and holds at 7.
